// File: rtl/clock_burst_sequencer.sv
// Clock burst sequencer: parks an external clock generator at a chosen idle
// level, lets it toggle for a commanded number of full cycles (counted on
// edges that return the clock to idle), then reports completion.
// Optional build macro CLKS_ALOT_BURST_HOLD_EN adds a hold/pause interface.
module clock_burst_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             clk_en,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CNT_W-1:0] cmd_cycles_i,
  input  logic             cmd_idle_high_i,
  input  logic             abort_i,
  input  logic             half_rate_elapsed_i,
  input  logic             clock_state_i,
`ifdef CLKS_ALOT_BURST_HOLD_EN
  input  logic             hold_i,
  output logic             pause_en_o,
  output logic             pause_polarity_o,
`endif
  output logic             set_clock_low_o,
  output logic             set_clock_high_o,
  output logic             clear_state_o,
  output logic             clock_active_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] remaining_o
);

  typedef enum logic [1:0] {StIdle, StPark, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             idle_q, idle_d;
  logic             abort_q, abort_d;
  logic             set_low_q, set_low_d;
  logic             set_high_q, set_high_d;
  logic             clear_q, clear_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             hold_pause;
  logic             return_edge;

`ifdef CLKS_ALOT_BURST_HOLD_EN
  // Pause request is only meaningful while the generator is running.
  assign hold_pause       = hold_i & (state_q == StRun);
  assign pause_en_o       = hold_pause;
  assign pause_polarity_o = idle_q;
`else
  assign hold_pause = 1'b0;
`endif

  // A half-period strobe while the clock sits away from idle brings it back:
  // that edge completes one full output cycle.
  assign return_edge = half_rate_elapsed_i & (clock_state_i != idle_q) & ~hold_pause;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idle_d      = idle_q;
    abort_d     = abort_q;
    set_low_d   = 1'b0;
    set_high_d  = 1'b0;
    clear_d     = 1'b0;
    active_d    = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d     = StPark;
          remaining_d = cmd_cycles_i;
          idle_d      = cmd_idle_high_i;
          set_high_d  = cmd_idle_high_i;
          set_low_d   = ~cmd_idle_high_i;
          clear_d     = 1'b1;
        end
      end
      StPark: begin
        if (remaining_q != '0) begin
          state_d  = StRun;
          active_d = 1'b1;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StRun: begin
        active_d = 1'b1;
        if (abort_i) abort_d = 1'b1;
        if (return_edge) begin
          remaining_d = remaining_q - CntOne;
          // Final count wins over a pending abort.
          if (remaining_q == CntOne) begin
            state_d  = StDone;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else if (abort_q | abort_i) begin
            state_d   = StDone;
            active_d  = 1'b0;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        abort_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; every update is qualified by clk_en.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      idle_q      <= 1'b0;
      abort_q     <= 1'b0;
      set_low_q   <= 1'b0;
      set_high_q  <= 1'b0;
      clear_q     <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idle_q      <= idle_d;
      abort_q     <= abort_d;
      set_low_q   <= set_low_d;
      set_high_q  <= set_high_d;
      clear_q     <= clear_d;
      active_q    <= active_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign cmd_ready_o      = (state_q == StIdle);
  assign busy_o           = (state_q != StIdle);
  // Pulses are masked while frozen so a stalled cycle is not seen twice.
  assign set_clock_low_o  = set_low_q & clk_en;
  assign set_clock_high_o = set_high_q & clk_en;
  assign clear_state_o    = clear_q & clk_en;
  assign done_o           = done_q & clk_en;
  assign clock_active_o   = active_q;
  assign aborted_o        = aborted_q;
  assign remaining_o      = remaining_q;

endmodule

// File: tb/tb_clock_burst_sequencer.sv
// Bench for clock_burst_sequencer: a small clock-generator model responds to
// the sequencer's controls; burst outcomes are predicted from the command,
// the observed number of completed output cycles and the abort point.
module tb_clock_burst_sequencer;
  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            async_rst;
  logic            clk_en;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [CntW-1:0] cmd_cycles_i;
  logic            cmd_idle_high_i;
  logic            abort_i;
  logic            half_rate_elapsed_i;
  logic            clock_state_i;
  logic            set_clock_low_o;
  logic            set_clock_high_o;
  logic            clear_state_o;
  logic            clock_active_o;
  logic            busy_o;
  logic            done_o;
  logic            aborted_o;
  logic [CntW-1:0] remaining_o;
`ifdef CLKS_ALOT_BURST_HOLD_EN
  logic            hold_i;
  logic            pause_en_o;
  logic            pause_polarity_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  clock_burst_sequencer #(.CNT_W(CntW)) dut (
    .clk                 (clk),
    .async_rst           (async_rst),
    .clk_en              (clk_en),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .cmd_cycles_i        (cmd_cycles_i),
    .cmd_idle_high_i     (cmd_idle_high_i),
    .abort_i             (abort_i),
    .half_rate_elapsed_i (half_rate_elapsed_i),
    .clock_state_i       (clock_state_i),
`ifdef CLKS_ALOT_BURST_HOLD_EN
    .hold_i              (hold_i),
    .pause_en_o          (pause_en_o),
    .pause_polarity_o    (pause_polarity_o),
`endif
    .set_clock_low_o     (set_clock_low_o),
    .set_clock_high_o    (set_clock_high_o),
    .clear_state_o       (clear_state_o),
    .clock_active_o      (clock_active_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .aborted_o           (aborted_o),
    .remaining_o         (remaining_o)
  );

  always #5 clk = ~clk;

  // Environment: rate counter strobing every 4th enabled cycle, and a clock
  // generator that is forced by set_* and toggles on strobes when active.
  logic       gen_level = 1'b0;
  logic [1:0] half_cnt  = 2'd0;
  logic       idle_ref  = 1'b0;
  logic       mon_clr   = 1'b0;
  int         ret_cnt   = 0;
  int         done_cnt  = 0;
  int         high_set_cnt = 0;
  logic       act_seen  = 1'b0;

  assign half_rate_elapsed_i = (half_cnt == 2'd3);
  assign clock_state_i       = gen_level;

  always @(posedge clk) begin
    if (clk_en) begin
      half_cnt <= half_cnt + 2'd1;
      if (set_clock_high_o) gen_level <= 1'b1;
      else if (set_clock_low_o) gen_level <= 1'b0;
      else if (clock_active_o && half_rate_elapsed_i) gen_level <= ~gen_level;
    end
    if (mon_clr) begin
      ret_cnt      <= 0;
      done_cnt     <= 0;
      high_set_cnt <= 0;
      act_seen     <= 1'b0;
    end else if (clk_en) begin
      if (!set_clock_high_o && !set_clock_low_o && clock_active_o && half_rate_elapsed_i &&
          gen_level != idle_ref)
        ret_cnt <= ret_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      if (set_clock_high_o) high_set_cnt <= high_set_cnt + 1;
      if (clock_active_o) act_seen <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input int n, input logic idle);
    mon_clr = 1'b1;
    tick();
    mon_clr         = 1'b0;
    idle_ref        = idle;
    cmd_cycles_i    = CntW'(n);
    cmd_idle_high_i = idle;
    cmd_valid_i     = 1'b1;
    chk("ready_before_accept", {31'b0, cmd_ready_o}, 32'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic finish_burst(input int exp_ret, input logic exp_ab, input int exp_rem);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("done_within_budget", {31'b0, ok}, 32'd1);
    chk("aborted_at_done", {31'b0, aborted_o}, {31'b0, exp_ab});
    chk("remaining_at_done", {16'b0, remaining_o}, exp_rem);
    chk("inactive_at_done", {31'b0, clock_active_o}, 32'd0);
    tick();
    chk("ready_after_done", {31'b0, cmd_ready_o}, 32'd1);
    chk("cycles_generated", ret_cnt, exp_ret);
    chk("left_at_idle", {31'b0, gen_level}, {31'b0, idle_ref});
    tick();
    tick();
    chk("done_once", done_cnt, 32'd1);
  endtask

  // Waits (bounded) until the generator model reaches a given point.
  task automatic wait_for(input int rets, input logic lvl, input int hc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ret_cnt == rets && gen_level == lvl && (hc < 0 || int'(half_cnt) == hc)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, delay;
    logic idle, do_abort;

    async_rst = 1'b1; clk_en = 1'b1; cmd_valid_i = 1'b0; cmd_cycles_i = '0;
    cmd_idle_high_i = 1'b0; abort_i = 1'b0;
`ifdef CLKS_ALOT_BURST_HOLD_EN
    hold_i = 1'b0;
`endif
    #3;
    chk("rst_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_remaining", {16'b0, remaining_o}, 32'd0);
    chk("rst_pulses", {28'b0, done_o, set_clock_low_o, set_clock_high_o, clear_state_o}, 32'd0);
    chk("rst_active_aborted", {30'b0, clock_active_o, aborted_o}, 32'd0);
    tick();
    tick();
    async_rst = 1'b0;
    tick();

    // Three cycles, idle low.
    start_burst(3, 1'b0);
    chk("park_set_low", {31'b0, set_clock_low_o}, 32'd1);
    chk("park_set_high", {31'b0, set_clock_high_o}, 32'd0);
    chk("park_clear", {31'b0, clear_state_o}, 32'd1);
    chk("park_busy_inactive", {30'b0, busy_o, clock_active_o}, 32'd2);
    tick();
    chk("active_two_after_accept", {31'b0, clock_active_o}, 32'd1);
    finish_burst(3, 1'b0, 0);

    // Zero cycles, idle high.
    start_burst(0, 1'b1);
    chk("zero_park_set_high", {31'b0, set_clock_high_o}, 32'd1);
    tick();
    chk("zero_done_two_after_accept", {31'b0, done_o}, 32'd1);
    finish_burst(0, 1'b0, 0);
    chk("zero_high_set_once", high_set_cnt, 32'd1);
    chk("zero_never_active", {31'b0, act_seen}, 32'd0);

    // Ten cycles, abort mid high phase at remaining 7.
    start_burst(10, 1'b0);
    wait_for(3, 1'b1, 1, "reach_rem7_high");
    chk("rem_before_abort", {16'b0, remaining_o}, 32'd7);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    finish_burst(4, 1'b1, 6);

    // One cycle, abort on the final return edge.
    start_burst(1, 1'b0);
    wait_for(0, 1'b1, 3, "reach_final_edge");
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    finish_burst(1, 1'b0, 0);

    // Freeze for five cycles mid-run.
    start_burst(5, 1'b1);
    wait_for(2, 1'b0, -1, "reach_freeze_point");
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("freeze_remaining", {16'b0, remaining_o}, 32'd3);
      chk("freeze_state", {29'b0, busy_o, clock_active_o, done_o}, 32'd6);
    end
    clk_en = 1'b1;
    finish_burst(5, 1'b0, 0);

    // Reset mid-run at remaining 4.
    start_burst(8, 1'b0);
    wait_for(4, 1'b1, -1, "reach_rem4");
    chk("rem_before_reset", {16'b0, remaining_o}, 32'd4);
    #2;
    async_rst = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("midrst_outputs", {27'b0, busy_o, clock_active_o, done_o, aborted_o, set_clock_low_o},
        32'd0);
    chk("midrst_remaining", {16'b0, remaining_o}, 32'd0);
    tick();
    tick();
    @(negedge clk);
    async_rst = 1'b0;
    tick();
    chk("midrst_no_done", done_cnt, 32'd0);

    // Randomised bursts with optional abort.
    for (int it = 0; it < 8; it++) begin
      n        = int'($urandom_range(1, 6));
      idle     = 1'(($urandom_range(0, 1)));
      do_abort = 1'(($urandom_range(0, 1)));
      delay    = int'($urandom_range(0, 8 * 6));
      start_burst(n, idle);
      tick();
      chk("rand_active", {31'b0, clock_active_o}, 32'd1);
      if (do_abort) begin
        for (int d = 0; d < delay; d++) begin
          if (ret_cnt == n - 1 && gen_level != idle_ref) break;
          tick();
        end
        k = ret_cnt;
        chk("rand_rem_at_abort", {16'b0, remaining_o}, n - k);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        finish_burst(k + 1, 1'(k + 1 < n), n - k - 1);
      end else begin
        finish_burst(n, 1'b0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_burst_sequencer.md
CLOCK_BURST_SEQUENCER -- requirements
Module: clock_burst_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of cycle count and remaining-count paths.
REQ-002 SHALL have ports:
- clk  in  1  system clock.
- async_rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  qualifies every state/register update.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  command accepted when valid&ready&clk_en.
- cmd_cycles_i  in  CNT_W  number of full output clock cycles in the burst.
- cmd_idle_high_i  in  1  park level (1 = high, 0 = low).
- abort_i  in  1  request early stop.
- half_rate_elapsed_i  in  1  rate-counter half-period strobe.
- clock_state_i  in  1  current unpausable generated clock level.
- set_clock_low_o  out  1  force generated clock low.
- set_clock_high_o  out  1  force generated clock high.
- clear_state_o  out  1  clear generator pause/event state.
- clock_active_o  out  1  enable generator toggling.
- busy_o  out  1  burst in progress (state != IDLE).
- done_o  out  1  one-cycle burst-complete pulse.
- aborted_o  out  1  valid with done_o; burst ended by abort.
- remaining_o  out  CNT_W  cycles still to generate.

Function
REQ-003 SHALL implement states IDLE, PARK, RUN, DONE; all transitions occur only on clk_en-high cycles.
REQ-004 IDLE: cmd_ready_o=1; on accept latch cmd_cycles_i into remaining and cmd_idle_high_i into idle level; go to PARK.
REQ-005 PARK (one enabled cycle): set_clock_high_o=idle level, set_clock_low_o=~idle level, clear_state_o=1; next RUN if remaining!=0, else DONE.
REQ-006 RUN: clock_active_o=1 (registered, asserted from the first RUN cycle).
REQ-007 RUN: a return edge is half_rate_elapsed_i=1 with clock_state_i != idle level; each return edge decrements remaining by 1.
REQ-008 Return edge with remaining==1 SHALL transition to DONE; clock_active_o is 0 on the following cycle, so the generator is left at idle level.
REQ-009 abort_i=1 in RUN SHALL set a sticky abort flag; the next return edge then transitions to DONE regardless of remaining; remaining_o holds its post-decrement value.
REQ-010 Return edge on final count coincident with abort_i SHALL report aborted_o=0.
REQ-011 DONE (one enabled cycle): done_o=1, aborted_o=abort flag, clock_active_o=0; next IDLE; abort flag cleared.
REQ-012 abort_i in IDLE, PARK or DONE SHALL be ignored.
REQ-013 cmd_cycles_i=0 SHALL still perform PARK, then DONE with aborted_o=0, without asserting clock_active_o.
REQ-014 Burst latency: accept to first clock_active_o=1 SHALL be 2 enabled cycles; cmd_ready_o returns 1 the cycle after done_o.
REQ-015 half_rate_elapsed_i outside RUN SHALL be ignored; the block relies on half_rate_elapsed_i never being high on two consecutive enabled cycles.
REQ-016 clk_en=0 SHALL freeze state, counter and all registered outputs; pulse outputs (done_o, set_clock_*_o, clear_state_o) SHALL be qualified by clk_en.
REQ-017 cmd_ready_o and busy_o SHALL be decoded from state; other outputs registered.

Reset
REQ-018 async_rst=1 SHALL immediately force IDLE, remaining=0, abort flag=0, and all outputs 0 except cmd_ready_o=1.
REQ-019 Reset asserted mid-burst SHALL abandon the burst without done_o; the generator clock level is left undefined until the next PARK.

Configuration
REQ-020 Macro CLKS_ALOT_BURST_HOLD_EN, when defined, SHALL add ports hold_i (in 1), pause_en_o (out 1) and pause_polarity_o (out 1).
REQ-021 With the macro defined: pause_en_o=hold_i while RUN, else 0; pause_polarity_o=idle level; return edges SHALL not be counted while pause_en_o=1.
REQ-022 Without the macro: the ports SHALL be absent and behaviour SHALL be per REQ-003..017.

Verification
REQ-023 Bench SHALL cover:
- cmd_cycles=3, idle low, half strobe every 4 cycles -> 3 high pulses, done_o once, aborted_o=0, remaining_o=0, clock left low.
- cmd_cycles=0, idle high -> PARK asserts set_clock_high_o once, done_o two enabled cycles after accept, clock_active_o never 1.
- cmd_cycles=10, abort_i at remaining=7 mid high phase -> stop at next falling return edge, done_o with aborted_o=1, remaining_o=6.
- cmd_cycles=1, abort_i coincident with final return edge -> aborted_o=0.
- clk_en low for 5 cycles mid-RUN -> no state, count or output change; burst resumes.
- async_rst pulse mid-RUN at remaining=4 -> outputs 0, cmd_ready_o=1 same cycle, no done_o.
